// File: rtl/bp_be_pkg.sv
// Back-end shared package: global widths, the PC the back end expects
// after reset, and the instruction-queue entry layout.
package bp_be_pkg;

  localparam int bp_be_itag_width_gp = 8;
  localparam int bp_vaddr_width_gp   = 39;
  localparam int bp_instr_width_gp   = 32;

  // First PC the front end delivers after reset.
  localparam logic [bp_vaddr_width_gp-1:0] bp_pc_entry_point_gp = 39'h00_8000_0124;

  // One queue slot at the default widths. The queue module packs the same
  // fields in the same order ({pc, instr, itag}) for any width configuration.
  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0]   pc;
    logic [bp_instr_width_gp-1:0]   instr;
    logic [bp_be_itag_width_gp-1:0] itag;
  } bp_be_instr_queue_entry_s;

endpackage

// File: rtl/bp_be_instr_queue_mem.sv
// 1R1W register array backing the instruction queue; asynchronous read,
// write on the rising edge. Contents are not reset.
module bp_be_instr_queue_mem
  import bp_be_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = $bits(bp_be_instr_queue_entry_s),
  localparam int addr_w_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Storage write; no reset since occupancy is tracked by the queue.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_instr_queue.sv
// Back-end instruction queue: filters fetch packets against an expected PC,
// tags stored packets with a wrapping 8-bit itag and issues in order.
// Optional macro BP_BE_INSTR_QUEUE_BYPASS_EN: when the queue is empty a
// storable packet is presented on the issue port in the same cycle.
module bp_be_instr_queue
  import bp_be_pkg::*;
#(
  parameter int els_p         = 4,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  localparam int ptr_w_lp     = $clog2(els_p),
  localparam int cnt_w_lp     = $clog2(els_p+1),
  localparam int entry_w_lp   = vaddr_width_p + instr_width_p + bp_be_itag_width_gp
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           fe_v_i,
  input  logic [vaddr_width_p-1:0]       fe_pc_i,
  input  logic [instr_width_p-1:0]       fe_instr_i,
  output logic                           fe_ready_o,
  output logic                           issue_v_o,
  output logic [vaddr_width_p-1:0]       issue_pc_o,
  output logic [instr_width_p-1:0]       issue_instr_o,
  output logic [bp_be_itag_width_gp-1:0] issue_itag_o,
  input  logic                           issue_yumi_i,
  input  logic                           flush_i,
  input  logic [vaddr_width_p-1:0]       redirect_pc_i,
  output logic [cnt_w_lp-1:0]            count_o
);

  logic [cnt_w_lp-1:0]            count_q, count_d;
  logic [ptr_w_lp-1:0]            head_q, head_d, tail_q, tail_d;
  logic [vaddr_width_p-1:0]       exp_pc_q, exp_pc_d;
  logic [bp_be_itag_width_gp-1:0] itag_q, itag_d;

  logic                  empty, store, write_v, deq_v;
  logic [entry_w_lp-1:0] w_data, r_data;

  assign empty      = (count_q == '0);
  assign fe_ready_o = (count_q < cnt_w_lp'(els_p));
  assign count_o    = count_q;

  // A packet is stored only if accepted, on the expected path, and not flushed.
  assign store  = fe_v_i & fe_ready_o & ~flush_i & (fe_pc_i == exp_pc_q);
  assign w_data = {fe_pc_i, fe_instr_i, itag_q};

`ifdef BP_BE_INSTR_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming packet; if consumed now it is never written.
  always_comb begin
    write_v   = store & ~(empty & issue_yumi_i);
    deq_v     = issue_yumi_i & ~empty & ~flush_i;
    issue_v_o = ~empty | store;
    {issue_pc_o, issue_instr_o, issue_itag_o} = empty ? w_data : r_data;
  end
`else
  // Issue strictly from storage: one cycle from store to visibility.
  always_comb begin
    write_v   = store;
    deq_v     = issue_yumi_i & ~empty & ~flush_i;
    issue_v_o = ~empty;
    {issue_pc_o, issue_instr_o, issue_itag_o} = r_data;
  end
`endif

  // Next-state for occupancy, pointers, expected PC and itag counter.
  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    exp_pc_d = exp_pc_q;
    itag_d   = itag_q;
    if (flush_i) begin
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      exp_pc_d = redirect_pc_i;
    end else begin
      if (store) begin
        exp_pc_d = exp_pc_q + vaddr_width_p'(4);
        itag_d   = itag_q + 1'b1;
      end
      if (write_v) tail_d = tail_q + 1'b1;
      if (deq_v)   head_d = head_q + 1'b1;
      case ({write_v, deq_v})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      exp_pc_q <= vaddr_width_p'(bp_pc_entry_point_gp);
      itag_q   <= '0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      exp_pc_q <= exp_pc_d;
      itag_q   <= itag_d;
    end
  end

  bp_be_instr_queue_mem #(
    .els_p   (els_p),
    .width_p (entry_w_lp)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (write_v),
    .w_addr_i (tail_q),
    .w_data_i (w_data),
    .r_addr_i (head_q),
    .r_data_o (r_data)
  );

endmodule

// File: tb/tb_bp_be_instr_queue.sv
// Directed bench for bp_be_instr_queue with default parameters.
module tb_bp_be_instr_queue;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        fe_v_i;
  logic [38:0] fe_pc_i;
  logic [31:0] fe_instr_i;
  logic        fe_ready_o;
  logic        issue_v_o;
  logic [38:0] issue_pc_o;
  logic [31:0] issue_instr_o;
  logic [7:0]  issue_itag_o;
  logic        issue_yumi_i;
  logic        flush_i;
  logic [38:0] redirect_pc_i;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;
  logic [38:0] pc;

  always #5 clk_i = ~clk_i;

  bp_be_instr_queue dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .fe_v_i        (fe_v_i),
    .fe_pc_i       (fe_pc_i),
    .fe_instr_i    (fe_instr_i),
    .fe_ready_o    (fe_ready_o),
    .issue_v_o     (issue_v_o),
    .issue_pc_o    (issue_pc_o),
    .issue_instr_o (issue_instr_o),
    .issue_itag_o  (issue_itag_o),
    .issue_yumi_i  (issue_yumi_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    fe_v_i = 0; issue_yumi_i = 0; flush_i = 0;
  endtask

  initial begin
    reset_n_i = 0; idle(); fe_pc_i = '0; fe_instr_i = '0; redirect_pc_i = '0;
    #12;
    check("rst_count", 64'(count_o), 0);
    check("rst_v", 64'(issue_v_o), 0);
    check("rst_ready", 64'(fe_ready_o), 1);
    reset_n_i = 1;
    step();

    // Off-path packet dropped.
    fe_v_i = 1; fe_pc_i = 39'h80000000; fe_instr_i = 32'hDEAD0000;
    step();
    check("drop_count", 64'(count_o), 0);
    check("drop_v", 64'(issue_v_o), 0);

    // Two in-path packets.
    fe_pc_i = 39'h80000124; fe_instr_i = 32'h11111111;
    step();
    check("st0_count", 64'(count_o), 1);
    check("st0_v", 64'(issue_v_o), 1);
    check("st0_pc", 64'(issue_pc_o), 64'h80000124);
    check("st0_itag", 64'(issue_itag_o), 0);
    check("st0_instr", 64'(issue_instr_o), 64'h11111111);
    fe_pc_i = 39'h80000128; fe_instr_i = 32'h22222222;
    step();
    check("st1_count", 64'(count_o), 2);
    fe_v_i = 0; issue_yumi_i = 1;
    step();
    check("pop0_pc", 64'(issue_pc_o), 64'h80000128);
    check("pop0_itag", 64'(issue_itag_o), 1);
    check("pop0_count", 64'(count_o), 1);
    step();
    check("pop1_count", 64'(count_o), 0);
    check("pop1_v", 64'(issue_v_o), 0);
    // Yumi while empty is ignored.
    step();
    check("yumi_empty_count", 64'(count_o), 0);
    issue_yumi_i = 0;

    // Fill: itags 2..5.
    fe_v_i = 1;
    for (int i = 0; i < 4; i++) begin
      fe_pc_i = 39'h8000012C + 39'(4*i); fe_instr_i = 32'(i);
      step();
    end
    check("full_count", 64'(count_o), 4);
    check("full_ready", 64'(fe_ready_o), 0);
    check("full_head_itag", 64'(issue_itag_o), 2);
    // Enqueue attempt with yumi while full: only the pop happens.
    fe_pc_i = 39'h8000013C; issue_yumi_i = 1;
    step();
    check("full_yumi_count", 64'(count_o), 3);
    check("full_yumi_head", 64'(issue_itag_o), 3);
    issue_yumi_i = 0;
    step();
    check("refill_count", 64'(count_o), 4);

    // Flush wins over same-cycle enqueue and yumi.
    flush_i = 1; redirect_pc_i = 39'h80001000; fe_pc_i = 39'h80001000; issue_yumi_i = 1;
    step();
    check("flush_count", 64'(count_o), 0);
    check("flush_v", 64'(issue_v_o), 0);
    flush_i = 0; issue_yumi_i = 0;
    step();
    check("redir_count", 64'(count_o), 1);
    check("redir_pc", 64'(issue_pc_o), 64'h80001000);
    check("redir_itag", 64'(issue_itag_o), 7);

    // Stream itags 8..255 with continuous yumi; then one more wraps to 0.
    flush_i = 1; redirect_pc_i = 39'h80002000; fe_v_i = 0;
    step();
    flush_i = 0; fe_v_i = 1; issue_yumi_i = 1;
    pc = 39'h80002000;
    for (int i = 0; i < 248; i++) begin
      fe_pc_i = pc; fe_instr_i = 32'(i);
      step();
      pc = pc + 4;
    end
    check("stream_count", 64'(count_o), 1);
    check("itag_255", 64'(issue_itag_o), 255);
    fe_pc_i = pc;
    step();
    check("itag_wrap", 64'(issue_itag_o), 0);
    check("wrap_pc", 64'(issue_pc_o), 64'(pc));
    fe_v_i = 0;
    step();
    check("drain_count", 64'(count_o), 0);
    issue_yumi_i = 0;

`ifdef BP_BE_INSTR_QUEUE_BYPASS_EN
    fe_v_i = 1; fe_pc_i = pc + 4; issue_yumi_i = 1;
    #1;
    check("byp_v", 64'(issue_v_o), 1);
    check("byp_itag", 64'(issue_itag_o), 1);
    step();
    check("byp_count", 64'(count_o), 0);
    idle();
`endif

    // Mid-operation reset drops entries.
    fe_v_i = 1; fe_pc_i = pc + 4;
    step();
    fe_v_i = 0;
    reset_n_i = 0;
    #1;
    check("rst2_count", 64'(count_o), 0);
    check("rst2_v", 64'(issue_v_o), 0);
    reset_n_i = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_instr_queue.md
BP_BE_INSTR_QUEUE -- requirements
Module: bp_be_instr_queue

Interface
REQ-001 SHALL have parameter els_p, default 4, meaning queue depth (power of two, >=2).
REQ-002 SHALL have parameter vaddr_width_p, default 39, meaning PC width.
REQ-003 SHALL have parameter instr_width_p, default 32, meaning instruction width.
REQ-004 SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port fe_v_i  in  1  FE fetch packet valid.
REQ-007 SHALL have port fe_pc_i  in  vaddr_width_p  fetch PC.
REQ-008 SHALL have port fe_instr_i  in  instr_width_p  fetched instruction.
REQ-009 SHALL have port fe_ready_o  out  1  queue can accept a packet.
REQ-010 SHALL have port issue_v_o  out  1  head entry valid.
REQ-011 SHALL have port issue_pc_o  out  vaddr_width_p  head PC.
REQ-012 SHALL have port issue_instr_o  out  instr_width_p  head instruction.
REQ-013 SHALL have port issue_itag_o  out  bp_be_itag_width_gp  head instruction tag.
REQ-014 SHALL have port issue_yumi_i  in  1  consumer takes head this cycle.
REQ-015 SHALL have port flush_i  in  1  discard all entries and redirect.
REQ-016 SHALL have port redirect_pc_i  in  vaddr_width_p  new expected PC, sampled when flush_i=1.
REQ-017 SHALL have port count_o  out  $clog2(els_p+1)  occupancy.

Function
REQ-018 SHALL accept a packet when fe_v_i & fe_ready_o; fe_ready_o = (count < els_p) from registered state only; no enqueue while full, even with a same-cycle yumi.
REQ-019 SHALL keep an expected-PC register; an accepted packet with fe_pc_i != expected PC is dropped (not stored, no itag consumed).
REQ-020 SHALL, on a stored packet, advance expected PC by 4 (modulo 2^vaddr_width_p) and write {pc, instr, itag} at the tail.
REQ-021 SHALL assign itags from an 8-bit counter incremented per stored packet, wrapping 255->0; flush does not reset it.
REQ-022 SHALL present head entry with issue_v_o = (count != 0); issue_yumi_i asserted with issue_v_o=0 is ignored.
REQ-023 SHALL, on simultaneous store and yumi (not full), keep count unchanged; head/tail pointers wrap modulo els_p.
REQ-024 SHALL give flush_i priority: same-cycle enqueue and yumi discarded, count=0 next cycle, expected PC := redirect_pc_i.
REQ-025 SHALL have one-cycle latency from store to issue_v_o (without bypass).

Reset
REQ-026 SHALL on reset_n_i=0 immediately set count_o=0, issue_v_o=0, fe_ready_o=1, pointers=0, itag counter=0, expected PC=bp_pc_entry_point_gp; storage contents need no reset.
REQ-027 SHALL, if reset asserts mid-operation, drop all entries; outputs of issue_pc_o/issue_instr_o/issue_itag_o are don't-care while issue_v_o=0.

Configuration
REQ-028 SHALL, with BP_BE_INSTR_QUEUE_BYPASS_EN defined, pass a storable packet to the issue port combinationally when the queue is empty (issue_v_o=1 same cycle); if yumi'd that cycle it is not written, itag still consumed; without the macro REQ-025 applies.

Structure
REQ-029 SHALL take bp_be_itag_width_gp and bp_pc_entry_point_gp from bp_be_pkg; the entry struct bp_be_instr_queue_entry_s {pc, instr, itag} SHALL be added to bp_be_pkg.
REQ-030 SHALL instantiate one sub-module, bp_be_instr_queue_mem, a 1R1W els_p-entry register array with asynchronous read.

Verification
REQ-031 Reset, then fe_pc_i=0x80000124,0x80000128 -> issued itags 0,1 with those PCs.
REQ-032 Post-reset fe_pc_i=0x80000000 -> dropped, count_o=0, next 0x80000124 gets itag 0.
REQ-033 Fill 4 entries, no yumi -> fe_ready_o=0; fe_v_i+yumi while full -> count 3, no store.
REQ-034 flush_i with redirect 0x80001000 plus same-cycle fe_v_i -> count 0; next 0x80001000 accepted, itag continues from prior value.
REQ-035 Store 256 packets -> 257th receives itag 0.
REQ-036 With BYPASS_EN, empty queue, fe_v_i+yumi same cycle -> issue_v_o=1 that cycle, count stays 0.
